// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_result_t;

  function automatic int unsigned calc_n(input int unsigned width,
                                         input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_magnitude_cmp_slice.sv
// Combinational DIGIT-bit unsigned comparator for one operand slice.
module slice_cmp #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_magnitude_cmp.sv
// MSB-first serial magnitude comparator, DIGIT bits per cycle, valid/ready on both sides.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing slice.
module serial_magnitude_cmp
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             busy
);

  localparam int unsigned N  = calc_n(WIDTH, DIGIT);
  localparam int unsigned CW = calc_cnt_w(N);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             dgt_q, dgt_d;
  logic             dlt_q, dlt_d;
  cmp_result_t      res_q, res_d;

  logic s_gt, s_lt, s_diff, last, exit_scan;

  // Operands shift left each scan cycle, so the active slice is always the top DIGIT bits.
  slice_cmp #(.DIGIT(DIGIT)) u_slice (
    .a_i  (a_q[WIDTH-1 -: DIGIT]),
    .b_i  (b_q[WIDTH-1 -: DIGIT]),
    .gt_o (s_gt),
    .lt_o (s_lt)
  );

  assign s_diff = s_gt | s_lt;
  assign last   = (cnt_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign exit_scan = last | (~dec_q & s_diff);
`else
  assign exit_scan = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      dec_q <= 1'b0;
      dgt_q <= 1'b0;
      dlt_q <= 1'b0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      dgt_q <= dgt_d;
      dlt_q <= dlt_d;
      res_q <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    dgt_d   = dgt_q;
    dlt_d   = dlt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          a_d     = signed_mode ? (a ^ MSB_MASK) : a;
          b_d     = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_d   = CNT_LOAD;
          dec_d   = 1'b0;
          dgt_d   = 1'b0;
          dlt_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (!dec_q && s_diff) begin
          dec_d = 1'b1;
          dgt_d = s_gt;
          dlt_d = s_lt;
        end
        if (exit_scan) begin
          res_d.gt = dec_q ? dgt_q : s_gt;
          res_d.lt = dec_q ? dlt_q : s_lt;
          res_d.eq = ~dec_q & ~s_diff;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    gt        = res_q.gt;
    lt        = res_q.lt;
    eq        = res_q.eq;
  end

endmodule
